// File: rtl/clock_time_counter_pkg.sv
// rtl/clock_time_counter_pkg.sv - shared types and limits for the clock time counter
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2
  } mode_e;

  typedef logic [3:0] bcd_t;

  localparam int SEC_MAX     = 59;
  localparam int MIN_MAX     = 59;
  localparam int HOUR_MAX_24 = 23;
  localparam int HOUR_MIN_12 = 1;
  localparam int HOUR_MAX_12 = 12;

endpackage

// File: rtl/clock_time_counter_if.sv
// rtl/clock_time_counter_if.sv - button inputs and display outputs of the time counter
// CLOCK_12H_EN adds the pm flag.
interface clock_time_counter_if;
  import clock_pkg::*;

  logic       btn_mode;
  logic       btn_inc;
  bcd_t       hr_t;
  bcd_t       hr_u;
  bcd_t       min_t;
  bcd_t       min_u;
  bcd_t       sec_t;
  bcd_t       sec_u;
  logic [5:0] digit_on;
  logic       sec_tick;
  logic [1:0] mode;
`ifdef CLOCK_12H_EN
  logic       pm;

  modport master (
    output btn_mode, btn_inc,
    input  hr_t, hr_u, min_t, min_u, sec_t, sec_u, digit_on, sec_tick, mode, pm
  );
  modport slave (
    input  btn_mode, btn_inc,
    output hr_t, hr_u, min_t, min_u, sec_t, sec_u, digit_on, sec_tick, mode, pm
  );
`else
  modport master (
    output btn_mode, btn_inc,
    input  hr_t, hr_u, min_t, min_u, sec_t, sec_u, digit_on, sec_tick, mode
  );
  modport slave (
    input  btn_mode, btn_inc,
    output hr_t, hr_u, min_t, min_u, sec_t, sec_u, digit_on, sec_tick, mode
  );
`endif

endinterface

// File: rtl/clock_time_counter_bcd_mod_counter.sv
// rtl/clock_time_counter_bcd_mod_counter.sv - two-digit BCD counter over MIN_VAL..MAX_VAL
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 59,
  parameter int RST_VAL = MIN_VAL
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output bcd_t tens,
  output bcd_t units,
  output logic carry
);

  localparam bcd_t MAX_T = 4'(MAX_VAL / 10);
  localparam bcd_t MAX_U = 4'(MAX_VAL % 10);
  localparam bcd_t MIN_T = 4'(MIN_VAL / 10);
  localparam bcd_t MIN_U = 4'(MIN_VAL % 10);
  localparam bcd_t RST_T = 4'(RST_VAL / 10);
  localparam bcd_t RST_U = 4'(RST_VAL % 10);

  bcd_t r_tens;
  bcd_t r_units;
  logic w_at_max;

  assign w_at_max = (r_tens == MAX_T) && (r_units == MAX_U);
  assign carry    = inc & ~clr & w_at_max;
  assign tens     = r_tens;
  assign units    = r_units;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tens  <= RST_T;
      r_units <= RST_U;
    end else if (clr) begin
      r_tens  <= MIN_T;
      r_units <= MIN_U;
    end else if (inc) begin
      if (w_at_max) begin
        r_tens  <= MIN_T;
        r_units <= MIN_U;
      end else if (r_units == 4'd9) begin
        r_tens  <= r_tens + 4'd1;
        r_units <= 4'd0;
      end else begin
        r_units <= r_units + 4'd1;
      end
    end
  end

endmodule

// File: rtl/clock_time_counter.sv
// rtl/clock_time_counter.sv - 1 Hz prescaler, HH:MM:SS BCD time and RUN/SET mode FSM
// CLOCK_12H_EN selects 12-hour display with a pm flag.
module clock_time_counter
  import clock_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BLINK_HALF = CLK_FREQ / 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  clock_time_counter_if.slave   bus
);

  localparam int PW = $clog2(CLK_FREQ);
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam logic [1:0] ST_RUN      = 2'(MODE_RUN);
  localparam logic [1:0] ST_SET_HOUR = 2'(MODE_SET_HOUR);
  localparam logic [1:0] ST_SET_MIN  = 2'(MODE_SET_MIN);

  logic [1:0]    r_mode;
  logic [1:0]    w_mode_nxt;
  logic [PW-1:0] r_presc;
  logic [BW-1:0] r_blink_cnt;
  logic [BW-1:0] w_blink_nxt;
  logic          r_phase;
  logic          w_phase_nxt;
  logic [5:0]    r_digit_on;
  logic [5:0]    w_digit_on_nxt;
  logic          r_sec_tick;
  logic          w_run;
  logic          w_tick;
  logic          w_inc;
  logic          w_inc_hr;
  logic          w_inc_min;
  logic          w_hr_inc;
  logic          w_enter_set_hour;
  logic          w_sec_carry;
  logic          w_min_carry;
  logic          w_hr_carry_unused;

  // A mode press takes priority: the same-cycle increment is dropped and no tick is taken.
  assign w_run            = (r_mode == ST_RUN);
  assign w_tick           = w_run & (r_presc == PW'(CLK_FREQ - 1)) & ~bus.btn_mode;
  assign w_inc            = bus.btn_inc & ~bus.btn_mode;
  assign w_inc_hr         = w_inc & (r_mode == ST_SET_HOUR);
  assign w_inc_min        = w_inc & (r_mode == ST_SET_MIN);
  assign w_enter_set_hour = bus.btn_mode & w_run;
  assign w_hr_inc         = (w_min_carry & w_sec_carry) | w_inc_hr;

  always_comb begin
    w_mode_nxt = r_mode;
    if (bus.btn_mode) begin
      case (r_mode)
        ST_RUN:      w_mode_nxt = ST_SET_HOUR;
        ST_SET_HOUR: w_mode_nxt = ST_SET_MIN;
        default:     w_mode_nxt = ST_RUN;
      endcase
    end
  end

  always_comb begin
    w_blink_nxt = r_blink_cnt;
    w_phase_nxt = r_phase;
    if (bus.btn_mode || w_run || w_inc) begin
      w_blink_nxt = '0;
      w_phase_nxt = 1'b1;
    end else if (r_blink_cnt == BW'(BLINK_HALF - 1)) begin
      w_blink_nxt = '0;
      w_phase_nxt = ~r_phase;
    end else begin
      w_blink_nxt = r_blink_cnt + 1'b1;
    end
  end

  always_comb begin
    w_digit_on_nxt = 6'h3F;
    case (w_mode_nxt)
      ST_SET_HOUR: w_digit_on_nxt = {{2{w_phase_nxt}}, 4'hF};
      ST_SET_MIN:  w_digit_on_nxt = {2'b11, {2{w_phase_nxt}}, 2'b11};
      default:     w_digit_on_nxt = 6'h3F;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode      <= ST_RUN;
      r_presc     <= '0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
      r_digit_on  <= 6'h3F;
      r_sec_tick  <= 1'b0;
    end else begin
      r_mode      <= w_mode_nxt;
      r_blink_cnt <= w_blink_nxt;
      r_phase     <= w_phase_nxt;
      r_digit_on  <= w_digit_on_nxt;
      r_sec_tick  <= w_tick;
      if (!w_run || bus.btn_mode || w_tick) r_presc <= '0;
      else                                  r_presc <= r_presc + 1'b1;
    end
  end

  bcd_mod_counter #(.MIN_VAL(0), .MAX_VAL(SEC_MAX)) u_sec (
    .clk(clk), .rst_n(rst_n), .inc(w_tick), .clr(w_enter_set_hour),
    .tens(bus.sec_t), .units(bus.sec_u), .carry(w_sec_carry)
  );

  bcd_mod_counter #(.MIN_VAL(0), .MAX_VAL(MIN_MAX)) u_min (
    .clk(clk), .rst_n(rst_n), .inc(w_sec_carry | w_inc_min), .clr(1'b0),
    .tens(bus.min_t), .units(bus.min_u), .carry(w_min_carry)
  );

`ifdef CLOCK_12H_EN
  logic r_pm;

  bcd_mod_counter #(.MIN_VAL(HOUR_MIN_12), .MAX_VAL(HOUR_MAX_12), .RST_VAL(HOUR_MAX_12)) u_hr (
    .clk(clk), .rst_n(rst_n), .inc(w_hr_inc), .clr(1'b0),
    .tens(bus.hr_t), .units(bus.hr_u), .carry(w_hr_carry_unused)
  );

  // AM/PM flips as the hour rolls from 11 into 12, whether by time or by setting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                                  r_pm <= 1'b0;
    else if (w_hr_inc && bus.hr_t == 4'd1 && bus.hr_u == 4'd1)   r_pm <= ~r_pm;
  end

  assign bus.pm = r_pm;
`else
  bcd_mod_counter #(.MIN_VAL(0), .MAX_VAL(HOUR_MAX_24)) u_hr (
    .clk(clk), .rst_n(rst_n), .inc(w_hr_inc), .clr(1'b0),
    .tens(bus.hr_t), .units(bus.hr_u), .carry(w_hr_carry_unused)
  );
`endif

  assign bus.mode     = r_mode;
  assign bus.digit_on = r_digit_on;
  assign bus.sec_tick = r_sec_tick;

endmodule

// File: tb/tb_clock_time_counter.sv
// tb/tb_clock_time_counter.sv - scoreboard bench for clock_time_counter against a seconds-of-day model
module tb_clock_time_counter;

  localparam int CF = 10;
  localparam int BH = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  clock_time_counter_if bus();

  clock_time_counter #(.CLK_FREQ(CF), .BLINK_HALF(BH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests  = 0;
  int n_fail   = 0;
  int tick_seen = 0;
  int bcd_bad  = 0;
  logic checking = 1'b0;
  logic [32:0] exp_q[$];

  // Reference model: time as seconds of day, plus cycle counts since run entry / blink restart.
  int m_tsec, m_mode, m_run_cnt, m_blink_k;
  logic m_tick;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] dut_out();
    return {bus.hr_t, bus.hr_u, bus.min_t, bus.min_u, bus.sec_t, bus.sec_u,
            bus.digit_on, bus.sec_tick, bus.mode};
  endfunction

  function automatic logic [23:0] time_bcd(input int tsec);
    int h, mi, s;
    h  = tsec / 3600;
    mi = (tsec / 60) % 60;
    s  = tsec % 60;
    return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [32:0] model_out();
    logic ph;
    logic [5:0] on;
    ph = ((m_blink_k / BH) % 2) == 0;
    if (m_mode == 1)      on = {ph, ph, 4'hF};
    else if (m_mode == 2) on = {2'b11, ph, ph, 2'b11};
    else                  on = 6'h3F;
    return {time_bcd(m_tsec), on, m_tick, 2'(m_mode)};
  endfunction

  task automatic model_reset();
    m_tsec = 0; m_mode = 0; m_run_cnt = 0; m_blink_k = 0; m_tick = 1'b0;
  endtask

  task automatic model_step(input logic bm, input logic bi);
    int h, mi, s;
    h  = m_tsec / 3600;
    mi = (m_tsec / 60) % 60;
    s  = m_tsec % 60;
    m_tick = 1'b0;
    if (bm) begin
      m_mode = (m_mode + 1) % 3;
      m_run_cnt = 0;
      m_blink_k = 0;
      if (m_mode == 1) s = 0;
      m_tsec = h * 3600 + mi * 60 + s;
    end else if (m_mode == 0) begin
      m_run_cnt++;
      if (m_run_cnt == CF) begin
        m_run_cnt = 0;
        m_tick = 1'b1;
        m_tsec = (m_tsec + 1) % 86400;
      end
    end else if (bi) begin
      m_blink_k = 0;
      if (m_mode == 1) h = (h + 1) % 24;
      else             mi = (mi + 1) % 60;
      m_tsec = h * 3600 + mi * 60 + s;
    end else begin
      m_blink_k++;
    end
  endtask

  // Called at a falling edge; applies inputs for the next rising edge and queues the expected result.
  task automatic drive(input logic bm, input logic bi);
    bus.btn_mode = bm;
    bus.btn_inc  = bi;
    model_step(bm, bi);
    exp_q.push_back(model_out());
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    checking = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", 64'(dut_out()), 64'({24'h0, 6'h3F, 1'b0, 2'd0}));
    exp_q.delete();
    model_reset();
    tick_seen = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("release_state", 64'(dut_out()), 64'({24'h0, 6'h3F, 1'b0, 2'd0}));
    checking = 1'b1;
  endtask

  always @(posedge clk) begin
    if (checking) begin
      #1;
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 64'(exp_q.size()), 64'd1);
      end else begin
        check("scoreboard", 64'(dut_out()), 64'(exp_q.pop_front()));
      end
      if (bus.sec_tick) tick_seen++;
      if (bus.sec_u > 4'd9 || bus.sec_t > 4'd5 || bus.min_u > 4'd9 ||
          bus.min_t > 4'd5 || bus.hr_u > 4'd9 || bus.hr_t > 4'd2) bcd_bad++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
  end

  initial begin
    int snap;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    model_reset();

    // First second after release, then a full minute of running.
    do_reset();
    idle(9);
    check("pre_first_tick", 64'({bus.sec_u, bus.sec_tick}), 64'({4'd0, 1'b0}));
    idle(1);
    check("first_tick", 64'({bus.sec_u, bus.sec_tick}), 64'({4'd1, 1'b1}));
    idle(590);
    check("one_minute", 64'(dut_out() >> 9), 64'(24'h000100));
    check("tick_count", 64'(tick_seen), 64'd60);
    check("bcd_valid", 64'(bcd_bad), 64'd0);

    // Set 23:59 and run across midnight.
    do_reset();
    drive(1'b1, 1'b0);
    for (int i = 0; i < 23; i++) drive(1'b0, 1'b1);
    drive(1'b1, 1'b0);
    for (int i = 0; i < 59; i++) drive(1'b0, 1'b1);
    drive(1'b1, 1'b0);
    check("set_2359", 64'(dut_out() >> 9), 64'(24'h235900));
    idle(600);
    check("midnight", 64'(dut_out() >> 9), 64'(24'h000000));

    // Hour wrap in SET_HOUR, frozen time and blinking.
    drive(1'b1, 1'b0);
    for (int i = 0; i < 23; i++) drive(1'b0, 1'b1);
    check("hour_23", 64'({bus.hr_t, bus.hr_u}), 64'(8'h23));
    drive(1'b0, 1'b1);
    check("hour_wrap", 64'({bus.hr_t, bus.hr_u, bus.min_t, bus.min_u}), 64'(16'h0000));
    snap = tick_seen;
    idle(100);
    check("frozen_ticks", 64'(tick_seen), 64'(snap));
    check("set_hour_low_on", 64'(bus.digit_on[3:0]), 64'(4'hF));

    // Simultaneous mode and increment: mode wins.
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    check("mode_wins", 64'({bus.mode, bus.hr_t, bus.hr_u}), 64'({2'd2, 8'h01}));
    drive(1'b0, 1'b1);
    check("min_inc_only", 64'({bus.hr_t, bus.hr_u, bus.min_t, bus.min_u}), 64'(16'h0101));
    drive(1'b1, 1'b0);

    // Randomized button activity checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0);
    check("bcd_valid_random", 64'(bcd_bad), 64'd0);

    // Reach 12:34:56 then reset asynchronously mid-cycle.
    do_reset();
    drive(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) drive(1'b0, 1'b1);
    drive(1'b1, 1'b0);
    for (int i = 0; i < 34; i++) drive(1'b0, 1'b1);
    drive(1'b1, 1'b0);
    idle(560);
    check("at_123456", 64'(dut_out() >> 9), 64'(24'h123456));
    do_reset();
    idle(20);

    checking = 1'b0;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_time_counter.md
Name: clock_time_counter

Overview:
- Timekeeping core of the digital clock: divides the system clock to a 1 Hz tick and keeps HH:MM:SS as six BCD digits.
- Runs a small RUN/SET_HOUR/SET_MIN state machine driven by pre-debounced single-cycle button pulses.
- Sits directly upstream of the six per-digit 7-segment decoders. Each decoder takes one 4-bit BCD digit plus one display-enable bit from this block; the enable bit implements set-mode blinking.

Parameters:
- CLK_FREQ, 50_000_000, system clock cycles per second; must be even and >= 4.
- BLINK_HALF, CLK_FREQ/2, cycles per blink half-period in set modes.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- btn_mode  input  1  one-cycle pulse, advance mode
- btn_inc  input  1  one-cycle pulse, increment selected field
- hr_t, hr_u, min_t, min_u, sec_t, sec_u  output  4 each  BCD digits, registered
- digit_on  output  6  per-digit display enable; bit5 = hr_t … bit0 = sec_u
- sec_tick  output  1  registered one-cycle pulse on each seconds advance
- mode  output  2  current state: 0 RUN, 1 SET_HOUR, 2 SET_MIN

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n). On assertion, all registers clear immediately, with no clock edge required:
  - digits 00:00:00, mode RUN, prescaler 0, blink counter 0, blink phase 1
  - digit_on = 6'b111111, sec_tick = 0
- Prescaler:
  - counts 0..CLK_FREQ-1 in RUN only;
  - at CLK_FREQ-1 it wraps to 0 and the seconds advance on that same edge, so the first advance after reset is exactly CLK_FREQ cycles later;
  - sec_tick is high for that one cycle.
- Seconds and minutes each count 00..59; a 59->00 wrap carries into the next field.
- Hours count 00..23; 23:59:59 -> 00:00:00 on a single edge.
- Digits are always valid BCD; the units digit never exceeds 9.
- FSM transitions on btn_mode: RUN -> SET_HOUR -> SET_MIN -> RUN.
- Entering SET_HOUR:
  - seconds forced to 00, prescaler cleared;
  - time frozen: no ticks, sec_tick stays 0, no carries.
- Returning to RUN: prescaler starts at 0, so the next tick comes CLK_FREQ cycles after the transition edge.
- btn_inc in SET_HOUR: hours +1, wrap 23 -> 00, no carry. In SET_MIN: minutes +1, wrap 59 -> 00, no carry into hours. Ignored in RUN.
- btn_mode and btn_inc asserted in the same cycle: the mode change wins and btn_inc is dropped.
- Blink:
  - the blink counter runs only in set modes; it toggles the phase every BLINK_HALF cycles, starting at phase 1 on set-mode entry;
  - SET_HOUR: digit_on[5:4] = phase, others 1;
  - SET_MIN: digit_on[3:2] = phase, others 1;
  - RUN: all 1.
  - btn_inc forces phase = 1 and restarts the blink counter, so the edited field stays visible.
- All outputs are registered; changes appear on the edge after the causing event.
- Pulse inputs held high for multiple cycles act once per cycle; debounce and edge detection are upstream.

Optional Feature:
- Macro CLOCK_12H_EN.
- Defined:
  - hours display 12,01..11 and an extra output port pm (1 bit, reset 0) is present;
  - pm toggles on the 11:59:59 -> 12:00:00 transition;
  - set-mode increment wraps 12 -> 01 and toggles pm on 11 -> 12;
  - reset value is 12:00:00 AM.
- Undefined: 24-hour behaviour as above; no pm port.

Decomposition:
- Package clock_pkg holds:
  - mode enum (MODE_RUN, MODE_SET_HOUR, MODE_SET_MIN)
  - bcd_t (4-bit) typedef
  - constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX_24=23, HOUR_MIN_12=1, HOUR_MAX_12=12
- Sub-module bcd_mod_counter:
  - two-digit BCD counter, parameters MIN_VAL/MAX_VAL;
  - inputs inc, clr; outputs tens, units, carry (high when inc at MAX_VAL);
  - instantiated three times for seconds, minutes and hours.

Test Plan (CLK_FREQ=10, BLINK_HALF=5):
- Reset then release -> 00:00:00, digit_on=6'h3F, mode=0, sec_tick=0; first sec_tick and sec_u=1 exactly 10 cycles after release.
- Run 600 cycles from reset -> 00:01:00; 60 sec_tick pulses counted; no non-BCD digit ever observed.
- Set 23:59 via 1 mode, 23 inc, 1 mode, 59 inc, 1 mode, then run 600 cycles -> 00:00:00 with hr_t=0, hr_u=0.
- In SET_HOUR with hours=23, pulse btn_inc -> 00, minutes unchanged, no sec_tick for 100 cycles; digit_on[5:4] toggles every 5 cycles, digit_on[3:0]=4'hF.
- btn_mode and btn_inc same cycle in SET_HOUR -> mode=2, hours unchanged; next btn_inc changes minutes only.
- rst_n driven low asynchronously between edges while running at 12:34:56 -> all outputs at reset values before the next rising edge.
